seq_gen_serial_tx: RTL and testbench

SEQ_GEN_SERIAL_TX -- requirements
Module: seq_gen_serial_tx

---
 rtl/seq_gen_serial_tx.sv | 120 ++++++++++++
 tb/tb_seq_gen_serial_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_serial_tx.sv
// Serial pattern transmitter: shifts an up-to-8-bit pattern MSB-of-length first, then G idle bits.
// Optional macro SEQ_GEN_PRBS_IDLE_EN replaces the constant-0 idle bit with a 7-bit LFSR (x^7+x^6+1).
module seq_gen_serial_tx #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [2:0]       len_in,
    input  logic [1:0]       gap_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_q, pat_nxt;
    logic [2:0]       bcnt_q, bcnt_nxt;
    logic [1:0]       gcnt_q, gcnt_nxt;
    logic [1:0]       gap_q, gap_nxt;
    logic             out_nxt, ov_nxt, done_nxt;
    logic             idle_bit;
    logic [2:0]       len_m1;

    // len_in=0 encodes 8; the 3-bit wrap of len_in-1 gives 7 for that case.
    assign len_m1    = len_in - 3'd1;
    assign ready_out = (state == IDLE);

`ifdef SEQ_GEN_PRBS_IDLE_EN
    logic [6:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr <= 7'h7F;
        end else if (!out_valid) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    assign idle_bit = lfsr[6];
`else
    assign idle_bit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_q;
        bcnt_nxt  = bcnt_q;
        gcnt_nxt  = gcnt_q;
        gap_nxt   = gap_q;
        out_nxt   = idle_bit;
        ov_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    pat_nxt   = pat_in;
                    gap_nxt   = gap_in;
                    bcnt_nxt  = len_m1;
                    out_nxt   = pat_in[len_m1];
                    ov_nxt    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bcnt_q != 3'd0) begin
                    out_nxt  = pat_q[bcnt_q - 3'd1];
                    ov_nxt   = 1'b1;
                    bcnt_nxt = bcnt_q - 3'd1;
                end else if (gap_q == 2'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = GAP;
                    gcnt_nxt  = gap_q - 2'd1;
                end
            end
            GAP: begin
                if (gcnt_q == 2'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    gcnt_nxt = gcnt_q - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            pat_q     <= '0;
            bcnt_q    <= '0;
            gcnt_q    <= '0;
            gap_q     <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pat_q     <= pat_nxt;
            bcnt_q    <= bcnt_nxt;
            gcnt_q    <= gcnt_nxt;
            gap_q     <= gap_nxt;
            out       <= out_nxt;
            out_valid <= ov_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_gen_serial_tx.sv
// Scoreboard bench for seq_gen_serial_tx; idle-bit expectation follows SEQ_GEN_PRBS_IDLE_EN.
module tb_seq_gen_serial_tx;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] pat_in = '0;
    logic [2:0] len_in = '0;
    logic [1:0] gap_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_out, out, out_valid, done;

    always #5 clk = ~clk;

    seq_gen_serial_tx #(.PAT_W(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .pat_in   (pat_in),
        .len_in   (len_in),
        .gap_in   (gap_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .out      (out),
        .out_valid(out_valid),
        .done     (done)
    );

    typedef struct {
        int len;
        int gap;
        int acc;
    } frame_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    logic   bits_q[$];
    frame_t frm_q[$];

    // cyc equals the index of the upcoming/current rising edge when read at that edge
    always @(negedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected bits and frame records as the DUT presents them.
    logic [6:0] m = 7'h7F;
    logic       exp_idle = 1'b0;
    bit         started = 1'b0;
    int         nb = 0;
    int         ni = 0;

    always @(posedge clk) begin
        logic   r, ov;
        int     e;
        frame_t f;
        r  = rstn;
        ov = out_valid;
        e  = cyc;
        if (!r) begin
            m        = 7'h7F;
            exp_idle = 1'b0;
            nb       = 0;
            ni       = 0;
            started  = 1'b1;
        end else begin
            exp_idle = m[6];
            if (ov === 1'b0) m = {m[5:0], m[6] ^ m[5]};
        end
`ifndef SEQ_GEN_PRBS_IDLE_EN
        exp_idle = 1'b0;
`endif
        #1;
        if (started) begin
            if (out_valid === 1'b1) begin
                chk("done_during_bits", done, 0);
                if (bits_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_bit: got out_valid=1 expected no pattern bit (t=%0t)", $time);
                end else begin
                    chk("bit", out, bits_q.pop_front());
                end
                nb++;
            end else begin
                chk("out_valid_known", out_valid, 0);
                chk("idle_out", out, exp_idle);
                if (done === 1'b1) begin
                    if (frm_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected 0 (t=%0t)", $time);
                    end else begin
                        f = frm_q.pop_front();
                        chk("frame_len", nb, f.len);
                        chk("frame_gap", ni, f.gap);
                        chk("done_latency", e - f.acc, f.len + f.gap);
                    end
                    nb = 0;
                    ni = 0;
                end else if (nb > 0) begin
                    ni++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer a pattern; nbits<0 means the full frame is expected, otherwise only that many bits.
    task automatic send(input logic [7:0] p, input logic [2:0] l, input logic [1:0] g,
                        input bit hold, input int nbits, output int acc);
        int L;
        int n;
        bit ok;
        L  = (l == 3'd0) ? 8 : int'(l);
        n  = (nbits < 0) ? L : nbits;
        ok = 1'b0;
        pat_in   = p;
        len_in   = l;
        gap_in   = g;
        valid_in = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (ready_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        acc = cyc;
        if (ok) begin
            for (int k = 0; k < n; k++) bits_q.push_back(p[L-1-k]);
            if (n == L) frm_q.push_back('{L, int'(g), cyc});
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready_out=0 for 64 cycles expected 1");
        end
        #1;
        if (!hold) valid_in = 1'b0;
    endtask

    initial begin
        int a1, a2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready_out, 1);
        rstn = 1'b1;
        tick;
        chk("ready_after_reset", ready_out, 1);
        repeat (10) tick;

        send(8'h05, 3'd3, 2'd0, 1'b0, -1, a1);   // 1,0,1
        repeat (6) tick;
        send(8'h06, 3'd3, 2'd2, 1'b0, -1, a1);   // 1,1,0 + 2 idle
        repeat (8) tick;
        send(8'hA5, 3'd0, 2'd0, 1'b0, -1, a1);   // 1,0,1,0,0,1,0,1
        repeat (10) tick;
        send(8'hFE, 3'd1, 2'd3, 1'b0, -1, a1);   // 0 + 3 idle
        repeat (8) tick;
        send(8'h55, 3'd7, 2'd1, 1'b0, -1, a1);   // 1,0,1,0,1,0,1 + 1 idle
        repeat (10) tick;

        send(8'h05, 3'd3, 2'd0, 1'b1, -1, a1);
        send(8'h06, 3'd3, 2'd0, 1'b0, -1, a2);
        chk("b2b_period", a2 - a1, 4);
        repeat (8) tick;

        // abort in the cycle showing the second bit of 8'h06; a load offered during reset must not take
        send(8'h06, 3'd3, 2'd2, 1'b0, 2, a1);
        tick;
        chk("abort_second_bit_valid", out_valid, 1);
        rstn     = 1'b0;
        pat_in   = 8'hFF;
        len_in   = 3'd0;
        valid_in = 1'b1;
        tick;
        chk("abort_out", out, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_done", done, 0);
        rstn     = 1'b1;
        valid_in = 1'b0;
        chk("abort_ready", ready_out, 1);
        repeat (12) tick;

        chk("bits_left", bits_q.size(), 0);
        chk("frames_left", frm_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
